// File: rtl/clk_period_meter.sv
// clk_period_meter: synchronizes a slow divided signal, regenerates edge pulses,
// measures period/high time in clkin cycles and reports lock and loss of signal.
module clk_period_meter #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 1000,
  parameter int LOCK_CNT    = 4,
  parameter int TOL         = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             sig_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [MW-1:0] MC_MAX = MW'(LOCK_CNT);
  localparam logic [CNT_W:0] TOL_X = (CNT_W + 1)'(TOL);

  typedef enum logic [1:0] {ST_WAIT, ST_RUN, ST_TMO} state_t;

  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic sig_d_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, hi_cap_q, hi_cap_d, period_q, period_d, high_q, high_d;
  logic [MW-1:0] mc_q, mc_d;
  logic first_q, first_d, rise_q, fall_q, pv_q, pv_d, locked_q, locked_d, tmo_q, tmo_d;
  logic sig_s, rise, fall, expire;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W:0] new_x, prev_x, diff;

  always_comb begin
    sync_d = '0;
    sync_d[0] = sig_in;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  assign sig_s   = sync_q[SYNC_STAGES-1];
  assign rise    = sig_s & ~sig_d_q;
  assign fall    = ~sig_s & sig_d_q;
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign expire  = ~rise & (cnt_q == CNT_LAST) & (state_q != ST_TMO);
  assign new_x   = {1'b0, cnt_inc};
  assign prev_x  = {1'b0, period_q};
  assign diff    = (new_x >= prev_x) ? new_x - prev_x : prev_x - new_x;

  // A rise always wins over the timeout check on the same edge, so a period
  // of exactly TIMEOUT is still published.
  always_comb begin
    state_d  = state_q;
    cnt_d    = rise ? '0 : (state_q == ST_TMO) ? cnt_q : cnt_inc;
    hi_cap_d = (fall && state_q == ST_RUN) ? cnt_inc : hi_cap_q;
    period_d = period_q;
    high_d   = high_q;
    pv_d     = 1'b0;
    mc_d     = mc_q;
    first_d  = first_q;
    locked_d = locked_q;
    tmo_d    = tmo_q;
    if (rise && state_q == ST_RUN) begin
      period_d = cnt_inc;
      high_d   = hi_cap_q;
      pv_d     = 1'b1;
      first_d  = 1'b0;
      mc_d     = first_q ? '0 : (diff <= TOL_X) ? ((mc_q == MC_MAX) ? mc_q : mc_q + MW'(1)) : '0;
      locked_d = (mc_d == MC_MAX);
    end else if (rise) begin
      state_d = ST_RUN;
      first_d = 1'b1;
      tmo_d   = 1'b0;
    end else if (expire) begin
      state_d  = ST_TMO;
      tmo_d    = 1'b1;
      locked_d = 1'b0;
      mc_d     = '0;
    end
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q  <= ST_WAIT;
      sync_q   <= '0;
      sig_d_q  <= 1'b0;
      cnt_q    <= '0;
      hi_cap_q <= '0;
      period_q <= '0;
      high_q   <= '0;
      mc_q     <= '0;
      first_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      pv_q     <= 1'b0;
      locked_q <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      sig_d_q  <= sig_s;
      cnt_q    <= cnt_d;
      hi_cap_q <= hi_cap_d;
      period_q <= period_d;
      high_q   <= high_d;
      mc_q     <= mc_d;
      first_q  <= first_d;
      rise_q   <= rise;
      fall_q   <= fall;
      pv_q     <= pv_d;
      locked_q <= locked_d;
      tmo_q    <= tmo_d;
    end
  end

  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign period       = period_q;
  assign high_time    = high_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign timeout      = tmo_q;
endmodule
